// File: rtl/system_bd_gpio_out_rmw_arbiter.sv
// Round-robin arbiter giving NUM_REQ fabric requesters atomic masked
// read-modify-write access to register 0 of the sys_gpio_out PIO slave.
module system_bd_gpio_out_rmw_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int IDX_W      = 2
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_mask,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_value,
    output logic [NUM_REQ-1:0]            ack,
    output logic                          busy,
    output logic [IDX_W-1:0]              grant_idx,
    output logic [DATA_WIDTH-1:0]         last_written,
    output logic [1:0]                    avm_address,
    output logic                          avm_chipselect,
    output logic                          avm_write_n,
    output logic [DATA_WIDTH-1:0]         avm_writedata,
    input  logic [DATA_WIDTH-1:0]         avm_readdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_ACK
    } state_e;

    state_e                  state_q,  state_d;
    logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]        grant_q,  grant_d;
    logic [DATA_WIDTH-1:0]   mask_q,   mask_d;
    logic [DATA_WIDTH-1:0]   val_q,    val_d;
    logic [NUM_REQ-1:0]      ack_q,    ack_d;
    logic                    cs_q,     cs_d;
    logic                    wrn_q,    wrn_d;
    logic [DATA_WIDTH-1:0]   wdata_q,  wdata_d;
    logic [DATA_WIDTH-1:0]   last_q,   last_d;

    logic                    win_found;
    logic [IDX_W-1:0]        win_idx;
    logic [IDX_W:0]          cand;

    function automatic logic [DATA_WIDTH-1:0] rmw_merge(
        input logic [DATA_WIDTH-1:0] old_val,
        input logic [DATA_WIDTH-1:0] mask,
        input logic [DATA_WIDTH-1:0] new_val
    );
        return (old_val & ~mask) | (new_val & mask);
    endfunction

    // Scan from lowest to highest priority so the highest-priority hit wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = {1'b0, rr_ptr_q} + (IDX_W + 1)'(k);
            if (cand >= (IDX_W + 1)'(NUM_REQ)) begin
                cand = cand - (IDX_W + 1)'(NUM_REQ);
            end
            if (req[cand[IDX_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        mask_d   = mask_q;
        val_d    = val_q;
        ack_d    = '0;
        cs_d     = 1'b0;
        wrn_d    = 1'b1;
        wdata_d  = wdata_q;
        last_d   = last_q;

        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    grant_d = win_idx;
                    mask_d  = req_mask[win_idx*DATA_WIDTH +: DATA_WIDTH];
                    val_d   = req_value[win_idx*DATA_WIDTH +: DATA_WIDTH];
                    cs_d    = 1'b1;
                    state_d = S_RD;
                end
            end
            S_RD: begin
                // Read data is merged as it is captured, so the registered
                // write data already holds the new register value in WR.
                wdata_d = rmw_merge(avm_readdata, mask_q, val_q);
                cs_d    = 1'b1;
                wrn_d   = 1'b0;
                state_d = S_WR;
            end
            S_WR: begin
                last_d         = wdata_q;
                ack_d[grant_q] = 1'b1;
                state_d        = S_ACK;
            end
            S_ACK: begin
                rr_ptr_d = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            mask_q   <= '0;
            val_q    <= '0;
            ack_q    <= '0;
            cs_q     <= 1'b0;
            wrn_q    <= 1'b1;
            wdata_q  <= '0;
            last_q   <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            mask_q   <= mask_d;
            val_q    <= val_d;
            ack_q    <= ack_d;
            cs_q     <= cs_d;
            wrn_q    <= wrn_d;
            wdata_q  <= wdata_d;
            last_q   <= last_d;
        end
    end

    assign ack            = ack_q;
    assign busy           = (state_q != S_IDLE);
    assign grant_idx      = grant_q;
    assign last_written   = last_q;
    assign avm_address    = 2'b00;
    assign avm_chipselect = cs_q;
    assign avm_write_n    = wrn_q;
    assign avm_writedata  = wdata_q;

endmodule

// File: tb/tb_system_bd_gpio_out_rmw_arbiter.sv
// Bench for the GPIO RMW arbiter: PIO register model, transaction-level
// reference checked every cycle, directed scenarios and random traffic.
module tb_system_bd_gpio_out_rmw_arbiter;
    localparam int N  = 4;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [N-1:0]    req;
    logic [N*DW-1:0] req_mask;
    logic [N*DW-1:0] req_value;
    logic [N-1:0]    ack;
    logic            busy;
    logic [1:0]      grant_idx;
    logic [DW-1:0]   last_written;
    logic [1:0]      avm_address;
    logic            avm_chipselect;
    logic            avm_write_n;
    logic [DW-1:0]   avm_writedata;
    logic [DW-1:0]   avm_readdata;

    logic [DW-1:0]   pio;
    logic            ext_we;
    logic [DW-1:0]   ext_data;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: phase 0 idle, 1 read, 2 write, 3 ack.
    int            m_phase = 0;
    int            m_grant = 0;
    int            m_rr    = 0;
    int            cyc     = 0;
    logic [DW-1:0] m_mask  = '0;
    logic [DW-1:0] m_val   = '0;
    logic [DW-1:0] m_exp   = '0;
    logic [DW-1:0] m_last  = '0;
    logic [DW-1:0] ref_pio = '0;

    int            ack_idx_q[$];
    int            ack_cyc_q[$];
    logic [DW-1:0] wr_q[$];

    always #5 clk = ~clk;

    system_bd_gpio_out_rmw_arbiter #(
        .NUM_REQ   (N),
        .DATA_WIDTH(DW),
        .IDX_W     (2)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req           (req),
        .req_mask      (req_mask),
        .req_value     (req_value),
        .ack           (ack),
        .busy          (busy),
        .grant_idx     (grant_idx),
        .last_written  (last_written),
        .avm_address   (avm_address),
        .avm_chipselect(avm_chipselect),
        .avm_write_n   (avm_write_n),
        .avm_writedata (avm_writedata),
        .avm_readdata  (avm_readdata)
    );

    // PIO register 0 with a second (external) writer port
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)                          pio <= '0;
        else if (avm_chipselect && !avm_write_n) pio <= avm_writedata;
        else if (ext_we)                       pio <= ext_data;
    end
    assign avm_readdata = pio;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        int            ph;
        bit            found;
        int            j;
        logic [N-1:0]  ea;
        if (!reset_n) begin
            chk("rst_busy",  32'(busy), 32'd0);
            chk("rst_cs",    32'(avm_chipselect), 32'd0);
            chk("rst_wrn",   32'(avm_write_n), 32'd1);
            chk("rst_ack",   32'(ack), 32'd0);
            chk("rst_grant", 32'(grant_idx), 32'd0);
            chk("rst_lw",    last_written, 32'd0);
            chk("rst_wd",    avm_writedata, 32'd0);
            m_phase = 0; m_grant = 0; m_rr = 0; m_last = '0; ref_pio = '0;
        end else begin
            ph = m_phase;
            ea = (ph == 3) ? (N'(1) << m_grant) : '0;
            chk("busy",  32'(busy), 32'(ph != 0));
            chk("cs",    32'(avm_chipselect), 32'(ph == 1 || ph == 2));
            chk("wrn",   32'(avm_write_n), 32'(ph != 2));
            chk("ack",   32'(ack), 32'(ea));
            chk("grant", 32'(grant_idx), 32'(m_grant));
            chk("lw",    last_written, m_last);
            chk("pio",   pio, ref_pio);
            chk("addr",  32'(avm_address), 32'd0);
            if (ph == 2) begin
                chk("wdata", avm_writedata, m_exp);
                wr_q.push_back(avm_writedata);
            end
            for (int i = 0; i < N; i++) begin
                if (ack[i]) begin
                    ack_idx_q.push_back(i);
                    ack_cyc_q.push_back(cyc);
                end
            end
            case (ph)
                0: begin
                    if (req != '0) begin
                        found = 1'b0;
                        for (int k = 0; k < N; k++) begin
                            j = (m_rr + k) % N;
                            if (!found && req[j]) begin
                                found   = 1'b1;
                                m_grant = j;
                            end
                        end
                        m_mask  = req_mask[m_grant*DW +: DW];
                        m_val   = req_value[m_grant*DW +: DW];
                        m_phase = 1;
                    end
                end
                1: begin
                    m_exp   = (ref_pio & ~m_mask) | (m_val & m_mask);
                    m_phase = 2;
                end
                2: begin
                    ref_pio = m_exp;
                    m_last  = m_exp;
                    m_phase = 3;
                end
                default: begin
                    m_rr    = (m_grant + 1) % N;
                    m_phase = 0;
                end
            endcase
            if (ext_we) ref_pio = ext_data;
        end
        cyc++;
    end

    // One clock; requesters drop req on the edge after they saw ack
    task automatic tick();
        logic [N-1:0] a;
        @(negedge clk);
        a = ack;
        @(posedge clk);
        #1;
        ext_we = 1'b0;
        req    = req & ~a;
    endtask

    task automatic set_req(input int i, input logic [DW-1:0] m, input logic [DW-1:0] v);
        req[i]               = 1'b1;
        req_mask[i*DW +: DW]  = m;
        req_value[i*DW +: DW] = v;
    endtask

    task automatic wait_acks(input int n, input int budget, input string tag);
        for (int t = 0; t < budget && ack_idx_q.size() < n; t++) tick();
        chk(tag, 32'(ack_idx_q.size()), 32'(n));
    endtask

    task automatic wait_idle(input int budget);
        for (int t = 0; t < budget && !(m_phase == 0 && req == '0); t++) tick();
    endtask

    task automatic pio_set(input logic [DW-1:0] v);
        wait_idle(50);
        ext_we   = 1'b1;
        ext_data = v;
        tick();
    endtask

    task automatic clear_logs();
        ack_idx_q.delete();
        ack_cyc_q.delete();
        wr_q.delete();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int c0;
        logic [DW-1:0] m;
        reset_n   = 1'b0;
        req       = '0;
        req_mask  = '0;
        req_value = '0;
        ext_we    = 1'b0;
        ext_data  = '0;
        tick();
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // Single update with latency
        clear_logs();
        set_req(0, 32'h0000_00FF, 32'h0000_00A5);
        c0 = cyc;
        wait_acks(1, 20, "single_timeout");
        chk("single_idx", 32'(ack_idx_q[0]), 32'd0);
        chk("single_lat", 32'(ack_cyc_q[0] - c0), 32'd3);
        chk("single_wd",  wr_q[0], 32'h0000_00A5);
        chk("single_lw",  last_written, 32'h0000_00A5);

        // Bit preservation
        pio_set(32'hFFFF_0000);
        clear_logs();
        set_req(2, 32'h0000_0F0F, 32'h0000_0505);
        wait_acks(1, 20, "bp_timeout");
        chk("bp_wd",  wr_q[0], 32'hFFFF_0505);
        chk("bp_pio", pio, 32'hFFFF_0505);

        // Fairness from rr_ptr=0
        do_reset();
        clear_logs();
        for (int i = 0; i < N; i++) set_req(i, $urandom, $urandom);
        wait_acks(4, 40, "fair_timeout");
        for (int i = 0; i < 4; i++) chk("fair_order", 32'(ack_idx_q[i]), 32'(i));
        for (int i = 1; i < 4; i++) chk("fair_gap", 32'(ack_cyc_q[i] - ack_cyc_q[i-1]), 32'd4);
        clear_logs();
        set_req(0, $urandom, $urandom);
        set_req(3, $urandom, $urandom);
        wait_acks(2, 30, "fair2_timeout");
        chk("fair2_first",  32'(ack_idx_q[0]), 32'd0);
        chk("fair2_second", 32'(ack_idx_q[1]), 32'd3);

        // Collision of two single-bit updates
        pio_set(32'h0);
        clear_logs();
        set_req(1, 32'h1, 32'h1);
        set_req(2, 32'h2, 32'h2);
        wait_acks(2, 30, "coll_timeout");
        chk("coll_first_idx", 32'(ack_idx_q[0]), 32'd1);
        chk("coll_wr0", wr_q[0], 32'h1);
        chk("coll_wr1", wr_q[1], 32'h3);
        chk("coll_pio", pio, 32'h3);

        // Reset asserted during the write cycle
        wait_idle(50);
        clear_logs();
        set_req(1, 32'h0000_00FF, 32'h0000_00C3);
        for (int t = 0; t < 10 && m_phase != 2; t++) tick();
        chk("rst_in_wr", 32'(avm_write_n), 32'd0);
        reset_n = 1'b0;
        #1;
        chk("rst_imm_cs",    32'(avm_chipselect), 32'd0);
        chk("rst_imm_ack",   32'(ack), 32'd0);
        chk("rst_imm_busy",  32'(busy), 32'd0);
        chk("rst_imm_grant", 32'(grant_idx), 32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        c0 = cyc;
        wait_acks(1, 20, "rst_timeout");
        chk("rst_retry_idx", 32'(ack_idx_q[0]), 32'd1);
        chk("rst_retry_lat", 32'(ack_cyc_q[0] - c0), 32'd3);
        chk("rst_retry_wd",  wr_q[0], 32'h0000_00C3);

        // Edge masks
        pio_set(32'h1234_5678);
        clear_logs();
        set_req(0, 32'h0, $urandom);
        wait_acks(1, 20, "m0_timeout");
        chk("mask0_idx", 32'(ack_idx_q[0]), 32'd0);
        chk("mask0_wd",  wr_q[0], 32'h1234_5678);
        clear_logs();
        set_req(3, 32'hFFFF_FFFF, 32'hDEAD_BEEF);
        wait_acks(1, 20, "m1_timeout");
        chk("mask1_wd", wr_q[0], 32'hDEAD_BEEF);

        // Random traffic with external writes and post-grant input changes
        for (int it = 0; it < 1500; it++) begin
            tick();
            for (int i = 0; i < N; i++) begin
                if (!req[i] && $urandom_range(0, 3) == 0) begin
                    case ($urandom_range(0, 3))
                        0:       m = 32'h0;
                        1:       m = 32'hFFFF_FFFF;
                        default: m = $urandom;
                    endcase
                    set_req(i, m, $urandom);
                end
            end
            if (m_phase != 0) begin
                req_mask[m_grant*DW +: DW]  = $urandom;
                req_value[m_grant*DW +: DW] = $urandom;
            end
            if ((m_phase == 0 || m_phase == 3) && $urandom_range(0, 7) == 0) begin
                ext_we   = 1'b1;
                ext_data = $urandom;
            end
        end
        wait_idle(200);
        chk("drain_req", 32'(req), 32'd0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
